// File: rtl/pc_next_unit.sv
// Program-counter stage of the single-cycle RV32I core: holds the architectural PC and
// selects PC+4, the branch/JAL target or the JALR target, with misaligned-target trap and halt.
module pc_next_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic        jalr,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        halt_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        mis_trap,
   output logic [31:0] mepc,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TRAP = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] br_tgt;
   logic [31:0] jalr_tgt;
   logic [31:0] tgt;
   logic        redirect;
   logic        misaligned;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      pc_plus4   = 32'h0;
      br_tgt     = 32'h0;
      jalr_tgt   = 32'h0;
      tgt        = 32'h0;
      redirect   = 1'b0;
      misaligned = 1'b0;

      pc_plus4   = pc + 32'd4;
      br_tgt     = pc + imm;
      jalr_tgt   = (rs1_data + imm) & 32'hFFFF_FFFE;
      tgt        = jalr ? jalr_tgt : br_tgt;
      redirect   = jalr | branch_taken;
      misaligned = redirect & (tgt[1:0] != 2'b00);
   end

   // Status flags are a pure decode of the state register, so they change only at clock edges.
   assign instr_valid = (state == ST_RUN);
   assign mis_trap    = (state == ST_TRAP);
   assign halted      = (state == ST_HALT);

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_RUN;
         pc    <= RESET_VECTOR;
         mepc  <= 32'h0;
      end else if (!stall) begin
         case (state)
            ST_RUN: begin
               if (misaligned) begin
                  // The bad target is never loaded; the faulting instruction's address is kept.
                  mepc  <= pc;
                  pc    <= TRAP_VECTOR;
                  state <= ST_TRAP;
               end else if (halt_req) begin
                  state <= ST_HALT;
               end else if (redirect) begin
                  pc <= tgt;
               end else begin
                  pc <= pc_plus4;
               end
            end
            // pc already holds TRAP_VECTOR; the handler's first instruction runs next in RUN.
            ST_TRAP: state <= ST_RUN;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit: reset, branch, JALR, misaligned trap, stall, halt
// and 32-bit wrap, each scenario in its own task with hand-computed expectations.
module tb_pc_next_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic        jalr;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        halt_req;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        mis_trap;
   logic [31:0] mepc;
   logic        halted;

   int n_cmp = 0;
   int n_err = 0;

   pc_next_unit #(
      .RESET_VECTOR(32'h0000_0000),
      .TRAP_VECTOR (32'h0000_0100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .branch_taken(branch_taken),
      .jalr        (jalr),
      .imm         (imm),
      .rs1_data    (rs1_data),
      .halt_req    (halt_req),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .mis_trap    (mis_trap),
      .mepc        (mepc),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit after it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall        = 1'b0;
      branch_taken = 1'b0;
      jalr         = 1'b0;
      imm          = 32'h0;
      rs1_data     = 32'h0;
      halt_req     = 1'b0;
   endtask

   // Jump to an aligned absolute address via JALR with imm=0.
   task automatic goto_pc(input logic [31:0] addr);
      idle_inputs();
      jalr     = 1'b1;
      rs1_data = addr;
      step();
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL rst_valid got=%b exp=1", instr_valid); end
      n_cmp++; if (mis_trap !== 1'b0) begin n_err++; $display("FAIL rst_trap got=%b exp=0", mis_trap); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got=%b exp=0", halted); end
      n_cmp++; if (mepc !== 32'h0) begin n_err++; $display("FAIL rst_mepc got=%h exp=%h", mepc, 32'h0); end
      rst_n = 1'b1;
      step();
      n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL seq_pc4 got=%h exp=%h", pc, 32'h4); end
      step();
      n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL seq_pc8 got=%h exp=%h", pc, 32'h8); end
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid got=%b exp=1", instr_valid); end
   endtask

   task automatic test_branch();
      step();
      step();
      n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL br_start got=%h exp=%h", pc, 32'h10); end
      branch_taken = 1'b1;
      imm          = 32'hFFFF_FFF8;
      #1;
      n_cmp++; if (pc_plus4 !== 32'h14) begin n_err++; $display("FAIL br_link got=%h exp=%h", pc_plus4, 32'h14); end
      step();
      n_cmp++; if (pc !== 32'h08) begin n_err++; $display("FAIL br_back got=%h exp=%h", pc, 32'h08); end
      // Back-to-back forward branch: 0x08 + 0x38 = 0x40.
      imm = 32'h38;
      step();
      idle_inputs();
      n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL br_fwd got=%h exp=%h", pc, 32'h40); end
   endtask

   task automatic test_jalr();
      jalr     = 1'b1;
      rs1_data = 32'h1003;
      imm      = 32'h1;
      step();
      n_cmp++; if (pc !== 32'h1004) begin n_err++; $display("FAIL jalr_tgt got=%h exp=%h", pc, 32'h1004); end
      goto_pc(32'h40);
      // With branch_taken also high the JALR target wins (branch target 0x41 would trap).
      jalr         = 1'b1;
      branch_taken = 1'b1;
      rs1_data     = 32'h1003;
      imm          = 32'h1;
      step();
      idle_inputs();
      n_cmp++; if (pc !== 32'h1004) begin n_err++; $display("FAIL jalr_prio got=%h exp=%h", pc, 32'h1004); end
      n_cmp++; if (mis_trap !== 1'b0) begin n_err++; $display("FAIL jalr_notrap got=%b exp=0", mis_trap); end
   endtask

   task automatic test_trap();
      goto_pc(32'h40);
      jalr     = 1'b1;
      rs1_data = 32'h1001;
      imm      = 32'h1;
      step();
      n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL trap_pc got=%h exp=%h", pc, 32'h100); end
      n_cmp++; if (mis_trap !== 1'b1) begin n_err++; $display("FAIL trap_flag got=%b exp=1", mis_trap); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL trap_valid got=%b exp=0", instr_valid); end
      n_cmp++; if (mepc !== 32'h40) begin n_err++; $display("FAIL trap_mepc got=%h exp=%h", mepc, 32'h40); end
      // Stall in TRAP holds it, misaligned jalr inputs still present.
      stall = 1'b1;
      step();
      n_cmp++; if (mis_trap !== 1'b1) begin n_err++; $display("FAIL trap_stall got=%b exp=1", mis_trap); end
      n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL trap_stall_pc got=%h exp=%h", pc, 32'h100); end
      // Leaving TRAP ignores redirect/halt inputs.
      stall    = 1'b0;
      halt_req = 1'b1;
      step();
      idle_inputs();
      n_cmp++; if (mis_trap !== 1'b0) begin n_err++; $display("FAIL trap_exit got=%b exp=0", mis_trap); end
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL trap_exit_valid got=%b exp=1", instr_valid); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL trap_exit_halt got=%b exp=0", halted); end
      n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL trap_exit_pc got=%h exp=%h", pc, 32'h100); end
      step();
      n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL trap_next got=%h exp=%h", pc, 32'h104); end
      // Misaligned branch target 0x104+2 = 0x106 traps; misaligned beats halt.
      branch_taken = 1'b1;
      halt_req     = 1'b1;
      imm          = 32'h2;
      step();
      idle_inputs();
      n_cmp++; if (mepc !== 32'h104) begin n_err++; $display("FAIL trap_br_mepc got=%h exp=%h", mepc, 32'h104); end
      n_cmp++; if (mis_trap !== 1'b1) begin n_err++; $display("FAIL trap_br_flag got=%b exp=1", mis_trap); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL trap_br_halt got=%b exp=0", halted); end
      step();
      n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL trap_br_pc got=%h exp=%h", pc, 32'h100); end
   endtask

   task automatic test_stall_halt();
      goto_pc(32'h20);
      stall        = 1'b1;
      branch_taken = 1'b1;
      imm          = 32'h100;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc, 32'h20); end
      end
      stall    = 1'b0;
      halt_req = 1'b1;
      step();
      n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag got=%b exp=1", halted); end
      n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL halt_pc got=%h exp=%h", pc, 32'h20); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid got=%b exp=0", instr_valid); end
      // HALT absorbs everything, including a misaligned JALR.
      halt_req = 1'b0;
      jalr     = 1'b1;
      rs1_data = 32'h2002;
      imm      = 32'h0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (pc !== 32'h20 || halted !== 1'b1) begin n_err++; $display("FAIL halt_hold[%0d] got=%h/%b exp=%h/1", i, pc, halted, 32'h20); end
      end
      n_cmp++; if (mepc !== 32'h104) begin n_err++; $display("FAIL halt_mepc got=%h exp=%h", mepc, 32'h104); end
      // Reset wins over HALT and a simultaneous stall.
      stall = 1'b1;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      idle_inputs();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL halt_rst_pc got=%h exp=%h", pc, 32'h0); end
      n_cmp++; if (halted !== 1'b0 || instr_valid !== 1'b1) begin n_err++; $display("FAIL halt_rst_state got=%b/%b exp=0/1", halted, instr_valid); end
      n_cmp++; if (mepc !== 32'h0) begin n_err++; $display("FAIL halt_rst_mepc got=%h exp=%h", mepc, 32'h0); end
   endtask

   task automatic test_wrap();
      goto_pc(32'hFFFF_FFFC);
      n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'hFFFF_FFFC); end
      n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_link got=%h exp=%h", pc_plus4, 32'h0); end
      step();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_next got=%h exp=%h", pc, 32'h0); end
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid got=%b exp=1", instr_valid); end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_branch();
      test_jalr();
      test_trap();
      test_stall_halt();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
